// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_seq : registered ALU, valid/ready handshake, iterative shift-add MUL   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         Opcode,
  input  logic [WIDTH-1:0]   Operand1,
  input  logic [WIDTH-1:0]   Operand2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Result,
  output logic               flagC,
  output logic               flagZ,
  output logic               flagN,
  output logic               flagV
);

  localparam int            CW        = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_LAST    = CW'(WIDTH - 1);
  localparam logic [2:0]    c_OP_ADD  = 3'b000;
  localparam logic [2:0]    c_OP_SUB  = 3'b001;
  localparam logic [2:0]    c_OP_MUL  = 3'b010;
  localparam logic [2:0]    c_OP_AND  = 3'b011;
  localparam logic [2:0]    c_OP_OR   = 3'b100;
  localparam logic [2:0]    c_OP_NAND = 3'b101;
  localparam logic [2:0]    c_OP_NOR  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_out_valid;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_flag_c;
  logic                 r_flag_z;
  logic                 r_flag_n;
  logic                 r_flag_v;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [CW-1:0]        r_cnt;

  logic                 w_accept;
  logic [WIDTH:0]       w_add;
  logic [WIDTH:0]       w_sub;
  logic [WIDTH-1:0]     w_low;
  logic                 w_c;
  logic                 w_v;
  logic [2*WIDTH-1:0]   w_alu_res;
  logic [2*WIDTH-1:0]   w_mul_res;

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign Result    = r_result;
  assign flagC     = r_flag_c;
  assign flagZ     = r_flag_z;
  assign flagN     = r_flag_n;
  assign flagV     = r_flag_v;

  assign w_add = {1'b0, Operand1} + {1'b0, Operand2};
  assign w_sub = {1'b0, Operand1} - {1'b0, Operand2};

  // Single-cycle ops; bit WIDTH of w_sub is the borrow
  always_comb begin
    w_low = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (Opcode)
      c_OP_ADD: begin
        w_low = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (Operand1[WIDTH-1] == Operand2[WIDTH-1]) &&
                (w_add[WIDTH-1] != Operand1[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_low = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (Operand1[WIDTH-1] != Operand2[WIDTH-1]) &&
                (w_sub[WIDTH-1] != Operand1[WIDTH-1]);
      end
      c_OP_AND:  w_low = Operand1 & Operand2;
      c_OP_OR:   w_low = Operand1 | Operand2;
      c_OP_NAND: w_low = ~(Operand1 & Operand2);
      c_OP_NOR:  w_low = ~(Operand1 | Operand2);
      default:   w_low = Operand1 ^ Operand2;
    endcase
  end

  assign w_alu_res = {{(WIDTH-1){1'b0}}, w_c, w_low};
  assign w_mul_res = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flag_c    <= 1'b0;
      r_flag_z    <= 1'b0;
      r_flag_n    <= 1'b0;
      r_flag_v    <= 1'b0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
    end else if (w_accept) begin
      if (Opcode == c_OP_MUL) begin
        r_state     <= S_MUL;
        r_out_valid <= 1'b0;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_mcand     <= {{WIDTH{1'b0}}, Operand1};
        r_mplier    <= Operand2;
      end else begin
        r_state     <= S_DONE;
        r_out_valid <= 1'b1;
        r_result    <= w_alu_res;
        r_flag_c    <= w_c;
        r_flag_z    <= (w_low == '0);
        r_flag_n    <= w_low[WIDTH-1];
        r_flag_v    <= w_v;
      end
    end else begin
      case (r_state)
        S_MUL: begin
          r_acc    <= w_mul_res;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == c_LAST) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_mul_res;
            r_flag_c    <= |w_mul_res[2*WIDTH-1:WIDTH];
            r_flag_z    <= (w_mul_res == '0);
            r_flag_n    <= w_mul_res[2*WIDTH-1];
            r_flag_v    <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// tb_alu_seq : directed and randomized checks of alu_seq against an arithmetic model
module tb_alu_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     Opcode;
  logic [W-1:0]   Operand1;
  logic [W-1:0]   Operand2;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] Result;
  logic           flagC, flagZ, flagN, flagV;
  logic [2*W+3:0] obs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign obs = {Result, flagC, flagZ, flagN, flagV};

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Opcode   (Opcode),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Result   (Result),
    .flagC    (flagC),
    .flagZ    (flagZ),
    .flagN    (flagN),
    .flagV    (flagV)
  );

  // Expected {Result, C, Z, N, V} from plain integer arithmetic
  function automatic logic [2*W+3:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int ia = a;
    int ib = b;
    int sa = $signed(a);
    int sb = $signed(b);
    int r;
    logic c = 1'b0;
    logic v = 1'b0;
    logic [2*W-1:0] res = '0;
    case (op)
      3'd0: begin r = ia + ib; res = 16'(r); c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      3'd1: begin c = (ia < ib); res = {7'd0, c, 8'(ia - ib)}; v = (sa - sb > 127) || (sa - sb < -128); end
      3'd2: begin r = ia * ib; res = 16'(r); c = (r > 255); end
      3'd3: res = {8'd0, a & b};
      3'd4: res = {8'd0, a | b};
      3'd5: res = {8'd0, ~(a & b)};
      3'd6: res = {8'd0, ~(a | b)};
      default: res = {8'd0, a ^ b};
    endcase
    if (op == 3'd2) return {res, c, (res == 16'd0), res[15], 1'b0};
    return {res, c, (res[7:0] == 8'd0), res[7], v};
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  // Accept one op at the next edge (state must be IDLE), then count edges until out_valid
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    @(negedge clk);
    in_valid = 1'b1; Opcode = op; Operand1 = a; Operand2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; Opcode = 3'($urandom); Operand1 = 8'($urandom); Operand2 = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    Opcode = '0; Operand1 = '0; Operand2 = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || obs !== '0) begin
      bad++; $display("FAIL reset_outputs: out_valid=%b obs=%h required 0/0", out_valid, obs);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_add();
    int lat;
    run_op(3'd0, 8'hC8, 8'h64, lat);
    total++;
    if (lat !== 0) begin bad++; $display("FAIL add_latency: got %0d required 0", lat); end
    total++;
    if (obs !== {16'h012C, 4'b1000}) begin
      bad++; $display("FAIL add_C8_64: got %h required %h", obs, {16'h012C, 4'b1000});
    end
    drain();
  endtask

  task automatic test_sub();
    int lat;
    run_op(3'd1, 8'h05, 8'h07, lat);
    total++;
    if (lat !== 0 || obs !== {16'h01FE, 4'b1010}) begin
      bad++; $display("FAIL sub_05_07: lat=%0d got %h required %h", lat, obs, {16'h01FE, 4'b1010});
    end
    drain();
    run_op(3'd1, 8'h80, 8'h01, lat);
    total++;
    if (lat !== 0 || obs !== {16'h007F, 4'b0001}) begin
      bad++; $display("FAIL sub_80_01: lat=%0d got %h required %h", lat, obs, {16'h007F, 4'b0001});
    end
    drain();
  endtask

  task automatic test_mul();
    int lat;
    @(negedge clk);
    in_valid = 1'b1; Opcode = 3'd2; Operand1 = 8'hFF; Operand2 = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        bad++; $display("FAIL mul_busy_cycle%0d: in_ready=%b out_valid=%b required 0/0", k, in_ready, out_valid);
      end
      @(posedge clk); #1;
    end
    total++;
    if (out_valid !== 1'b1 || obs !== {16'hFE01, 4'b1010}) begin
      bad++; $display("FAIL mul_FF_FF: out_valid=%b got %h required %h", out_valid, obs, {16'hFE01, 4'b1010});
    end
    drain();
    run_op(3'd2, 8'h00, 8'h37, lat);
    total++;
    if (lat !== W || obs !== {16'h0000, 4'b0100}) begin
      bad++; $display("FAIL mul_00_37: lat=%0d got %h required lat %0d %h", lat, obs, W, {16'h0000, 4'b0100});
    end
    drain();
  endtask

  task automatic test_logic();
    int lat;
    run_op(3'd3, 8'hF0, 8'h0F, lat);
    total++;
    if (lat !== 0 || obs !== {16'h0000, 4'b0100}) begin
      bad++; $display("FAIL and_F0_0F: lat=%0d got %h required %h", lat, obs, {16'h0000, 4'b0100});
    end
    drain();
    run_op(3'd5, 8'hFF, 8'hFF, lat);
    total++;
    if (lat !== 0 || obs !== {16'h0000, 4'b0100}) begin
      bad++; $display("FAIL nand_FF_FF: lat=%0d got %h required %h", lat, obs, {16'h0000, 4'b0100});
    end
    drain();
    run_op(3'd6, 8'h00, 8'h00, lat);
    total++;
    if (lat !== 0 || obs !== {16'h00FF, 4'b0010}) begin
      bad++; $display("FAIL nor_00_00: lat=%0d got %h required %h", lat, obs, {16'h00FF, 4'b0010});
    end
    drain();
  endtask

  task automatic test_hold();
    int lat;
    run_op(3'd7, 8'hAA, 8'h0F, lat);
    total++;
    if (lat !== 0 || obs !== {16'h00A5, 4'b0010}) begin
      bad++; $display("FAIL xor_AA_0F: lat=%0d got %h required %h", lat, obs, {16'h00A5, 4'b0010});
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== {16'h00A5, 4'b0010}) begin
        bad++; $display("FAIL hold_cycle%0d: out_valid=%b in_ready=%b obs=%h required 1/0/%h",
                        k, out_valid, in_ready, obs, {16'h00A5, 4'b0010});
      end
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; Opcode = 3'd4; Operand1 = 8'h01; Operand2 = 8'h02;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL done_ready_passthru: got %b required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b1 || obs !== {16'h0003, 4'b0000}) begin
      bad++; $display("FAIL b2b_or_01_02: out_valid=%b got %h required 1 %h", out_valid, obs, {16'h0003, 4'b0000});
    end
    drain();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_to_idle: out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    @(negedge clk);
    in_valid = 1'b1; Opcode = 3'd2; Operand1 = 8'h5A; Operand2 = 8'h3C;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || obs !== '0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid_mul: out_valid=%b obs=%h in_ready=%b required 0/0/1", out_valid, obs, in_ready);
    end
    @(negedge clk); reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mul_aborted: out_valid=%b required 0", out_valid); end
    run_op(3'd0, 8'h01, 8'h01, lat);
    total++;
    if (lat !== 0 || obs !== {16'h0002, 4'b0000}) begin
      bad++; $display("FAIL add_after_reset: lat=%0d got %h required %h", lat, obs, {16'h0002, 4'b0000});
    end
    drain();
  endtask

  task automatic test_random();
    int lat, hold;
    logic [2:0] op;
    logic [W-1:0] a, b;
    logic [2*W+3:0] exp;
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7)); a = pick_operand(); b = pick_operand();
      exp = model(op, a, b);
      run_op(op, a, b, lat);
      total++;
      if (lat !== ((op == 3'd2) ? W : 0) || obs !== exp) begin
        bad++; $display("FAIL rand%0d op=%0d a=%h b=%h: lat=%0d got %h required %h", n, op, a, b, lat, obs, exp);
      end
      hold = $urandom_range(0, 3);
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || obs !== exp) begin
          bad++; $display("FAIL rand_hold%0d: out_valid=%b got %h required %h", n, out_valid, obs, exp);
        end
      end
      drain();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [2:0] op1, op2;
    logic [W-1:0] a, b;
    logic [2*W+3:0] exp;
    for (int n = 0; n < 30; n++) begin
      op1 = 3'($urandom_range(0, 7)); a = pick_operand(); b = pick_operand();
      exp = model(op1, a, b);
      run_op(op1, a, b, lat);
      total++;
      if (lat !== ((op1 == 3'd2) ? W : 0) || obs !== exp) begin
        bad++; $display("FAIL b2b_first%0d op=%0d: lat=%0d got %h required %h", n, op1, lat, obs, exp);
      end
      op2 = 3'($urandom_range(0, 7)); a = pick_operand(); b = pick_operand();
      exp = model(op2, a, b);
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; Opcode = op2; Operand1 = a; Operand2 = b;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      if (op2 != 3'd2) begin
        total++;
        if (out_valid !== 1'b1 || obs !== exp) begin
          bad++; $display("FAIL b2b_second%0d op=%0d: out_valid=%b got %h required 1 %h", n, op2, out_valid, obs, exp);
        end
      end else begin
        total++;
        if (out_valid !== 1'b0) begin
          bad++; $display("FAIL b2b_mul_drop%0d: out_valid=%b required 0", n, out_valid);
        end
        lat = 0;
        while (!out_valid && lat < 40) begin
          @(posedge clk); #1;
          lat++;
        end
        total++;
        if (lat !== W || obs !== exp) begin
          bad++; $display("FAIL b2b_mul%0d: lat=%0d got %h required lat %0d %h", n, lat, obs, W, exp);
        end
      end
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_logic();
    test_hold();
    test_reset_mid_mul();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
